// File: rtl/snake_pkg.sv
// snake_pkg: shared state encoding, colour type and default raster geometry for the snake frame path
package snake_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, HANDOFF, SETTLE, CAPTURE, DONE} state_t;
  typedef logic [23:0] color_t;
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int X_W = 10;
  localparam int Y_W = 9;
endpackage

// File: rtl/snake_frame_writer_if.sv
// snake_frame_writer_if: producer draw handshake plus frame buffer write port
interface snake_frame_writer_if;
  import snake_pkg::*;
  logic           write_done;
  logic [X_W-1:0] rx;
  logic [Y_W-1:0] ry;
  logic           cleared;
  logic           fb_we;
  logic [X_W-1:0] fb_x;
  logic [Y_W-1:0] fb_y;
  color_t         fb_color;
  modport master (input write_done, rx, ry, output cleared, fb_we, fb_x, fb_y, fb_color);
  modport slave (output write_done, rx, ry, input cleared, fb_we, fb_x, fb_y, fb_color);
endinterface

// File: rtl/raster_counter.sv
// raster_counter: x/y raster sweep with synchronous start, per-cycle step and last-pixel flag
module raster_counter
  import snake_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic           draw_clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           step,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);
  logic last_x, last_y;
  assign last_x = x == X_W'(H_RES - 1);
  assign last_y = y == Y_W'(V_RES - 1);
  assign last = last_x && last_y;
  always_ff @(posedge draw_clk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (start) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      x <= last_x ? '0 : x + 1'b1;
      y <= last_x ? (last_y ? '0 : y + 1'b1) : y;
    end
  end
endmodule

// File: rtl/snake_frame_writer.sv
// snake_frame_writer: per-frame erase, producer handoff and capture of the snake pixel stream into the frame buffer
module snake_frame_writer
  import snake_pkg::*;
#(
  parameter int     H_RES      = H_RES_DEF,
  parameter int     V_RES      = V_RES_DEF,
  parameter int     MAX_PIXELS = 1600,
  parameter color_t BG_COLOR   = 24'h000000,
  parameter color_t FG_COLOR   = 24'h00FF00
) (
  input  logic                   draw_clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   frame_tick,
  snake_frame_writer_if.master   bus,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   timeout_err,
  output logic [7:0]             overrun_cnt
);
  localparam int CW = $clog2(MAX_PIXELS + 1);
  state_t         state;
  logic           pending, go, in_range, last_pixel;
  logic [CW-1:0]  cap_cnt, cap_next;
  logic [X_W-1:0] rc_x;
  logic [Y_W-1:0] rc_y;
  assign go = state == IDLE && enable && (frame_tick || pending);
  assign in_range = 32'(bus.rx) < H_RES && 32'(bus.ry) < V_RES;
  assign cap_next = cap_cnt + 1'b1;
  raster_counter #(.H_RES(H_RES), .V_RES(V_RES)) u_raster (
    .draw_clk (draw_clk),
    .reset_n  (reset_n),
    .start    (go),
    .step     (state == CLEAR),
    .x        (rc_x),
    .y        (rc_y),
    .last     (last_pixel)
  );
  // Outputs are registered one cycle behind the state that produces them.
  always_ff @(posedge draw_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      pending      <= 1'b0;
      cap_cnt      <= '0;
      bus.cleared  <= 1'b0;
      bus.fb_we    <= 1'b0;
      bus.fb_x     <= '0;
      bus.fb_y     <= '0;
      bus.fb_color <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      timeout_err  <= 1'b0;
      overrun_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      if (go) pending <= pending && frame_tick;
      else if (frame_tick) begin
        pending <= 1'b1;
        if (pending && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 1'b1;
      end
      case (state)
        IDLE: if (go) begin
          state   <= CLEAR;
          busy    <= 1'b1;
          cap_cnt <= '0;
        end
        CLEAR: begin
          bus.fb_we    <= 1'b1;
          bus.fb_x     <= rc_x;
          bus.fb_y     <= rc_y;
          bus.fb_color <= BG_COLOR;
          if (last_pixel) state <= HANDOFF;
        end
        HANDOFF: begin
          bus.fb_we   <= 1'b0;
          bus.cleared <= 1'b1;
          state       <= SETTLE;
        end
        SETTLE: begin
          bus.cleared <= 1'b0;
          state       <= CAPTURE;
        end
        CAPTURE: begin
          bus.fb_we    <= !bus.write_done && in_range;
          bus.fb_x     <= bus.rx;
          bus.fb_y     <= bus.ry;
          bus.fb_color <= FG_COLOR;
          if (bus.write_done) state <= DONE;
          else if (in_range) begin
            cap_cnt <= cap_next;
            if (cap_next == CW'(MAX_PIXELS)) begin
              timeout_err <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          bus.fb_we  <= 1'b0;
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_snake_frame_writer.sv
// tb_snake_frame_writer: directed table-driven bench for snake_frame_writer on a 16x12 raster
module tb_snake_frame_writer;
  localparam int H = 16;
  localparam int V = 12;
  localparam int MAXP = 40;
  localparam logic [23:0] BG = 24'h000000;
  localparam logic [23:0] FG = 24'h00FF00;
  typedef struct {
    logic       wd;
    logic [9:0] rx;
    logic [8:0] ry;
    logic       exp_we;
  } vec_t;
  logic draw_clk = 1'b0;
  logic reset_n, enable, frame_tick, busy, frame_done, timeout_err;
  logic [7:0] overrun_cnt;
  int checks = 0;
  int failures = 0;
  vec_t tbl [13];
  snake_frame_writer_if bus ();
  snake_frame_writer #(.H_RES(H), .V_RES(V), .MAX_PIXELS(MAXP), .BG_COLOR(BG), .FG_COLOR(FG)) dut (
    .draw_clk    (draw_clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .frame_tick  (frame_tick),
    .bus         (bus),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .overrun_cnt (overrun_cnt)
  );
  always #5 draw_clk = ~draw_clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic start_frame();
    frame_tick = 1'b1;
    @(negedge draw_clk);
    frame_tick = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
  endtask
  // Expects to be entered on the negedge right after the state became CLEAR.
  task automatic erase(input bit do_ticks, input int abort_at);
    for (int i = 0; i < H * V; i++) begin
      @(negedge draw_clk);
      chk("erase_px", 64'({bus.fb_we, bus.fb_x, bus.fb_y, bus.fb_color}),
          64'({1'b1, 10'(i % H), 9'(i / H), BG}));
      if (i == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk("abort_drop", 64'({bus.fb_we, bus.cleared, busy}), 64'd0);
        return;
      end
      frame_tick = do_ticks && (i == 10 || i == 20 || i == 30);
    end
  endtask
  task automatic handoff();
    @(negedge draw_clk);
    chk("handoff_cleared", 64'({bus.fb_we, bus.cleared}), 64'b01);
    bus.rx = 10'd4;
    bus.ry = 9'd4;
    @(negedge draw_clk);
    chk("settle_idle", 64'({bus.fb_we, bus.cleared}), 64'b00);
  endtask
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.write_done = tbl[i].wd;
      bus.rx = tbl[i].rx;
      bus.ry = tbl[i].ry;
      @(negedge draw_clk);
      if (tbl[i].exp_we)
        chk($sformatf("cap_vec%0d", i), 64'({bus.fb_we, bus.fb_x, bus.fb_y, bus.fb_color}),
            64'({1'b1, tbl[i].rx, tbl[i].ry, FG}));
      else
        chk($sformatf("cap_vec%0d_we", i), 64'(bus.fb_we), 64'd0);
    end
    bus.write_done = 1'b0;
  endtask
  task automatic finish_frame(input logic exp_busy);
    @(negedge draw_clk);
    chk("done_pulse", 64'({frame_done, busy, bus.fb_we}), 64'b100);
    @(negedge draw_clk);
    chk("done_after", 64'({frame_done, busy}), 64'({1'b0, exp_busy}));
  endtask
  initial begin
    tbl[0]  = '{1'b0, 10'd1,    9'd1,  1'b1};
    tbl[1]  = '{1'b0, 10'd2,    9'd1,  1'b1};
    tbl[2]  = '{1'b0, 10'd3,    9'd1,  1'b1};
    tbl[3]  = '{1'b1, 10'd9,    9'd9,  1'b0};
    tbl[4]  = '{1'b0, 10'd20,   9'd3,  1'b0};
    tbl[5]  = '{1'b0, 10'd5,    9'd5,  1'b1};
    tbl[6]  = '{1'b0, 10'd3,    9'd13, 1'b0};
    tbl[7]  = '{1'b0, 10'd1023, 9'd0,  1'b0};
    tbl[8]  = '{1'b0, 10'd15,   9'd11, 1'b1};
    tbl[9]  = '{1'b0, 10'd16,   9'd0,  1'b0};
    tbl[10] = '{1'b0, 10'd0,    9'd0,  1'b1};
    tbl[11] = '{1'b1, 10'd5,    9'd5,  1'b0};
    tbl[12] = '{1'b1, 10'd3,    9'd3,  1'b0};
    reset_n = 1'b0;
    enable = 1'b1;
    frame_tick = 1'b0;
    bus.write_done = 1'b0;
    bus.rx = '0;
    bus.ry = '0;
    repeat (2) @(negedge draw_clk);
    chk("reset_outs", 64'({bus.cleared, bus.fb_we, bus.fb_x, bus.fb_y, bus.fb_color}), 64'd0);
    chk("reset_status", 64'({busy, frame_done, timeout_err, overrun_cnt}), 64'd0);
    reset_n = 1'b1;
    start_frame();
    erase(1'b0, -1);
    handoff();
    run_vecs(0, 3);
    finish_frame(1'b0);
    chk("no_err", 64'({timeout_err, overrun_cnt}), 64'd0);
    start_frame();
    erase(1'b0, -1);
    handoff();
    run_vecs(4, 11);
    finish_frame(1'b0);
    start_frame();
    erase(1'b0, -1);
    handoff();
    for (int i = 0; i < MAXP; i++) begin
      bus.rx = 10'(i % H);
      bus.ry = 9'(i / H + 2);
      @(negedge draw_clk);
      chk($sformatf("timeout_px%0d", i), 64'({bus.fb_we, bus.fb_x, bus.fb_y}),
          64'({1'b1, 10'(i % H), 9'(i / H + 2)}));
      chk($sformatf("timeout_err%0d", i), 64'(timeout_err), 64'(i == MAXP - 1));
    end
    finish_frame(1'b0);
    start_frame();
    erase(1'b0, -1);
    handoff();
    run_vecs(12, 12);
    finish_frame(1'b0);
    chk("timeout_sticky", 64'(timeout_err), 64'd1);
    start_frame();
    erase(1'b1, -1);
    chk("overrun_cnt", 64'(overrun_cnt), 64'd2);
    handoff();
    run_vecs(12, 12);
    finish_frame(1'b1);
    erase(1'b0, -1);
    handoff();
    run_vecs(12, 12);
    finish_frame(1'b0);
    chk("overrun_hold", 64'(overrun_cnt), 64'd2);
    enable = 1'b0;
    frame_tick = 1'b1;
    @(negedge draw_clk);
    frame_tick = 1'b0;
    repeat (3) begin
      @(negedge draw_clk);
      chk("disabled_idle", 64'(busy), 64'd0);
    end
    enable = 1'b1;
    @(negedge draw_clk);
    chk("pending_start", 64'(busy), 64'd1);
    erase(1'b0, 4 * H + 7);
    @(negedge draw_clk);
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge draw_clk);
      chk("post_reset_quiet", 64'({bus.fb_we, bus.cleared, busy, frame_done}), 64'd0);
    end
    chk("post_reset_status", 64'({timeout_err, overrun_cnt}), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/snake_frame_writer.md
Name: snake_frame_writer

Overview:
- Consumer end of the snake pixel stream: owns the frame buffer write port and drives the producer's draw handshake.
- Per frame: erases the frame buffer to background, pulses `cleared` to the snake producer, then captures the producer's rx/ry stream and writes snake-coloured pixels until the producer raises `write_done`.
- Sits between the snake producer and the VGA frame buffer; started once per frame by `frame_tick` (vsync-derived).

Parameters:
- H_RES, 640, visible width in pixels; fb_x range 0..H_RES-1
- V_RES, 480, visible height in pixels; fb_y range 0..V_RES-1
- MAX_PIXELS, 1600, capture timeout in accepted stream cycles (16 squares x 100 pixels)
- BG_COLOR, 24'h000000, colour written during erase
- FG_COLOR, 24'h00FF00, colour written for snake pixels

Ports:
- draw_clk  in  1  system clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  frame starts allowed when 1
- frame_tick  in  1  single-cycle frame start request
- write_done  in  1  producer: stream finished
- rx  in  10  producer pixel x, treated as unsigned
- ry  in  9  producer pixel y, treated as unsigned
- cleared  out  1  one-cycle pulse to producer: restart stream
- fb_we  out  1  frame buffer write enable
- fb_x  out  10  frame buffer write x
- fb_y  out  9  frame buffer write y
- fb_color  out  24  frame buffer write data
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse on leaving DONE
- timeout_err  out  1  sticky; set on capture timeout, cleared only by reset
- overrun_cnt  out  8  saturating count of frame_tick dropped while busy

Behaviour:
- Reset (async, reset_n=0): state=IDLE; every output 0; pending flag=0; counters=0.
- All outputs are registered.
- IDLE:
  - `frame_tick & enable`, or `pending & enable` → CLEAR next cycle.
  - Pending clears on that transition.
- CLEAR:
  - Raster erase: fb_we=1, fb_color=BG_COLOR.
  - fb_x increments 0..H_RES-1, then wraps to 0 with fb_y+1.
  - After writing (H_RES-1, V_RES-1) → HANDOFF; exactly H_RES*V_RES writes.
- HANDOFF:
  - fb_we=0, cleared=1 for exactly one cycle → SETTLE.
- SETTLE:
  - One idle cycle while the producer's registered outputs update → CAPTURE.
  - Inputs are ignored in this cycle.
- CAPTURE, each cycle with write_done=0:
  - If rx<H_RES and ry<V_RES: fb_we=1, fb_x=rx, fb_y=ry, fb_color=FG_COLOR (one-cycle latency).
  - Otherwise the pixel is dropped and fb_we=0; this covers negative coordinates, which wrap to large unsigned values.
  - Each accepted cycle increments the capture counter.
- CAPTURE exits:
  - write_done=1 → DONE; that cycle's rx/ry is not written.
  - Capture counter reaches MAX_PIXELS with write_done still 0 → timeout_err=1, → DONE.
  - write_done already 1 in the first CAPTURE cycle → DONE with zero writes.
- DONE:
  - frame_done=1 for one cycle → IDLE.
  - Pending is serviced from IDLE on the next cycle.
- frame_tick while busy:
  - Sets pending; it is one-deep.
  - A tick arriving while pending is already set increments overrun_cnt, saturating at 255.
  - A tick in the same cycle as the DONE→IDLE transition counts as pending, not overrun.
- enable=0:
  - Does not abort a frame in progress.
  - Blocks only the IDLE→CLEAR transition; pending is retained.
- Reset mid-frame: immediate return to IDLE; cleared and fb_we drop asynchronously.
- Widths:
  - Erase counters are the same width as fb_x/fb_y; compares use `==H_RES-1` / `==V_RES-1`.
  - Capture counter is $clog2(MAX_PIXELS+1) bits.

Decomposition:
- Package snake_pkg holds:
  - state enum {IDLE, CLEAR, HANDOFF, SETTLE, CAPTURE, DONE}
  - color typedef (logic [23:0])
  - H_RES/V_RES defaults
- One sub-module, raster_counter: x/y sweep counter with start, step, last-pixel flag. It is reused by the VGA side.
- FSM, capture logic and error/overrun tracking live in snake_frame_writer.

Test Plan (bench uses H_RES=16, V_RES=12, MAX_PIXELS=40):
- Reset then frame_tick with enable=1 → exactly 192 BG writes in raster order (0,0)…(15,11), then cleared high for 1 cycle, then SETTLE, then CAPTURE.
- Model producer emits (1,1),(2,1),(3,1) then write_done → exactly 3 FG writes at those coords, frame_done pulse, busy=0.
- Producer emits (20,3), (3,13), (1023,0) → no writes for these; adjacent in-range pixel (5,5) written.
- Producer never asserts write_done → 40 accepted cycles then timeout_err=1, frame_done pulse; timeout_err persists through the next frame until reset_n=0.
- Three frame_ticks during CLEAR → one pending frame runs immediately after frame_done; overrun_cnt=2.
- reset_n asserted mid-CLEAR (at pixel (7,4)) → fb_we, cleared, busy drop same cycle; after release, no activity until next frame_tick.
